ddr_rd_sched: RTL

- Sequences DDR read bursts that fill the 128-bit pixel cache FIFO, all on sclk.
- Accepts a refill request from the pixel-side cache controller, which crosses in from the pixel_clk domain.
- Issues one burst command per request with a linear frame address, forwards returned beats as FIFO write enables, and signals burst completion.
- Sits between the cache controller and the DDR/AXI read master.

---
 rtl/ddr_rd_sched.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/ddr_rd_sched.sv
// ddr_rd_sched
// Sequences DDR read bursts that refill the 128-bit pixel cache FIFO.
// A refill request arrives as a level on rd_start from the pixel_clk domain.
// Each request issues one burst command at a linear frame address. Returned
// beats are forwarded as cache FIFO writes, and burst completion is
// signalled with rd_end. Everything runs on sclk.
//
// Ports
//   sclk           in   system / DDR-side clock
//   rst_n          in   asynchronous active-low reset
//   rd_start       in   refill request level (asynchronous to sclk)
//   frame_sync     in   sclk pulse: the next burst restarts at BASE_ADDR
//   cmd_valid      out  burst command valid
//   cmd_ready      in   command accepted by the read master
//   cmd_addr       out  burst start byte address
//   cmd_len        out  beats per burst minus one (constant)
//   rd_data_valid  in   read master returning a beat
//   rd_data        in   beat data
//   cache_wr_en    out  cache FIFO write enable
//   rd_128bit_data out  cache FIFO write data
//   rd_end         out  one-cycle burst-complete pulse
//   busy           out  scheduler not idle
//   err            out  sticky beat-timeout flag
module ddr_rd_sched #(
  parameter int          ADDR_W       = 29,
  parameter int unsigned BASE_ADDR    = 0,
  parameter int          BURST_LEN    = 64,
  parameter int          FRAME_BURSTS = 3072,
  parameter int          TIMEOUT      = 1023
) (
  input  logic              sclk,
  input  logic              rst_n,
  input  logic              rd_start,
  input  logic              frame_sync,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [7:0]        cmd_len,
  input  logic              rd_data_valid,
  input  logic [127:0]      rd_data,
  output logic              cache_wr_en,
  output logic [127:0]      rd_128bit_data,
  output logic              rd_end,
  output logic              busy,
  output logic              err
);

  localparam int IDX_W = (FRAME_BURSTS > 1) ? $clog2(FRAME_BURSTS) : 1;
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  localparam logic [ADDR_W-1:0] BASE_V      = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(BURST_LEN * 16);
  localparam logic [7:0]        LAST_BEAT   = 8'(BURST_LEN - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(FRAME_BURSTS - 1);
  localparam logic [WD_W-1:0]   WD_LAST     = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

  state_t            state, state_nx;
  logic              sync_p0, sync_p1, sync_p2;
  logic              req_pulse;
  logic              req_pend;
  logic              fs_pend;
  logic              aborted;
  logic [7:0]        beat_cnt;
  logic [WD_W-1:0]   wdog;
  logic [IDX_W-1:0]  burst_idx;
  logic              vld_p1;
  logic [127:0]      data_p1;
  logic              beat_in;
  logic              timeout_hit;

  // ---- stage p0..p2: rd_start synchronizer and registered rising-edge detect
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0   <= 1'b0;
      sync_p1   <= 1'b0;
      sync_p2   <= 1'b0;
      req_pulse <= 1'b0;
    end else begin
      sync_p0   <= rd_start;
      sync_p1   <= sync_p0;
      sync_p2   <= sync_p1;
      req_pulse <= sync_p1 & ~sync_p2;
    end
  end

  assign beat_in     = (state == DATA) && rd_data_valid;
  assign timeout_hit = (state == DATA) && !rd_data_valid && (wdog == WD_LAST);

  // ---- burst sequencing FSM
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (req_pulse || req_pend) state_nx = CMD;
      CMD:  if (cmd_ready) state_nx = DATA;
      DATA: begin
        if (beat_in && (beat_cnt == LAST_BEAT)) state_nx = DONE;
        else if (timeout_hit)                   state_nx = DONE;
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    cmd_valid = (state == CMD);
    rd_end    = (state == DONE);
    busy      = (state != IDLE);
  end

  // ---- burst bookkeeping: counters, pending flags, frame position
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt  <= '0;
      wdog      <= '0;
      burst_idx <= '0;
      req_pend  <= 1'b0;
      fs_pend   <= 1'b0;
      aborted   <= 1'b0;
      err       <= 1'b0;
    end else begin
      // Leaving IDLE consumes any pending request; while busy, requests
      // (including one landing in DONE) merge into a single pending flag.
      req_pend <= (state != IDLE) ? (req_pend | req_pulse) : 1'b0;

      unique case (state)
        IDLE: begin
          if (frame_sync) burst_idx <= '0;
        end
        CMD: begin
          if (frame_sync) fs_pend <= 1'b1;
          if (cmd_ready) begin
            beat_cnt <= '0;
            wdog     <= '0;
            aborted  <= 1'b0;
          end
        end
        DATA: begin
          if (frame_sync) fs_pend <= 1'b1;
          if (rd_data_valid) begin
            beat_cnt <= beat_cnt + 8'd1;
            wdog     <= '0;
          end else begin
            wdog <= wdog + 1'b1;
          end
          if (timeout_hit) begin
            err     <= 1'b1;
            aborted <= 1'b1;
          end
        end
        DONE: begin
          // A frame restart wins over the normal advance; an aborted burst
          // keeps its index so the same address is fetched again.
          if (fs_pend || frame_sync) burst_idx <= '0;
          else if (!aborted)         burst_idx <= (burst_idx == LAST_IDX) ? '0 : burst_idx + 1'b1;
          fs_pend <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // ---- stage p1: returned beat registered into the cache write port
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= beat_in;
      if (beat_in) data_p1 <= rd_data;
    end
  end

  assign cache_wr_en    = vld_p1;
  assign rd_128bit_data = data_p1;
  assign cmd_len        = LAST_BEAT;
  // burst_idx only moves in IDLE or DONE, so the address is stable in CMD.
  assign cmd_addr       = BASE_V + ADDR_W'(burst_idx) * BURST_BYTES;

endmodule
